// File: rtl/osc_multi_model_pkg.sv
// +--------------------------------------------------------------------------+
// | osc_pkg : shared types and helpers for the multi-channel oscillator model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package osc_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    STARTUP = 2'd1,
    RUN     = 2'd2
  } osc_state_t;

  // Wide enough for the largest half-period minus one at the top select value.
  function automatic int ph_cnt_w(input int base_log2, input int sel_w);
    return base_log2 + (1 << sel_w) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/osc_div_ch.sv
// +--------------------------------------------------------------------------+
// | osc_div_ch : one divided, glitch-free gated output clock channel          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module osc_div_ch
  import osc_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int BASE_LOG2 = 10
) (
  input  logic             _clk,
  input  logic             _rst,
  input  logic             load,
  input  logic             run,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic             clk_out
);

  localparam int               c_cnt_w   = ph_cnt_w(BASE_LOG2, SEL_W);
  localparam logic [SEL_W-1:0] c_sel_max = '1;

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_last;
  logic [SEL_W-1:0]   r_sel_lat;
  logic [SEL_W-1:0]   w_shift;
  logic               r_en_lat;
  logic               r_out;
  logic               w_wrap;

  // H-1 = all-ones of width BASE_LOG2+sel, built by right-shifting a full mask.
  assign w_shift = c_sel_max - r_sel_lat;
  assign w_last  = {c_cnt_w{1'b1}} >> w_shift;
  assign w_wrap  = (r_cnt == w_last);
  assign clk_out = r_out;

  always_ff @(posedge _clk or posedge _rst) begin
    if (_rst) begin
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_sel_lat <= '0;
      r_en_lat  <= 1'b0;
    end else if (load) begin
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_sel_lat <= sel;
      r_en_lat  <= en;
    end else if (run) begin
      if (w_wrap) begin
        r_cnt <= '0;
        // Settings only change at a low-going boundary, so a high phase is never cut short.
        if (r_out) begin
          r_out     <= 1'b0;
          r_sel_lat <= sel;
          r_en_lat  <= en;
        end else if (r_en_lat) begin
          r_out <= 1'b1;
        end else begin
          r_sel_lat <= sel;
          r_en_lat  <= en;
        end
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end else begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/osc_multi_model.sv
// +--------------------------------------------------------------------------+
// | osc_multi_model : oscillator model with power-up sequencing and N gated   |
// |                   divided output clocks derived from _clk                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module osc_multi_model
  import osc_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int SEL_W       = 2,
  parameter int BASE_LOG2   = 10,
  parameter int STARTUP_CYC = 64
) (
  input  logic                  _clk,
  input  logic                  _rst,
  input  logic                  pu,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*SEL_W-1:0] sel,
  output logic [N_CH-1:0]       clk_out,
  output logic                  ready
);

  localparam int               c_su_w    = $clog2(STARTUP_CYC + 1);
  localparam logic [c_su_w-1:0] c_su_last = c_su_w'(STARTUP_CYC - 1);

  osc_state_t        r_state;
  osc_state_t        w_next;
  logic [c_su_w-1:0] r_su_cnt;
  logic              r_ready;
  logic              w_load;
  logic              w_run;

  always_ff @(posedge _clk or posedge _rst) begin
    if (_rst) begin
      r_state  <= OFF;
      r_su_cnt <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ready  <= (w_next == RUN);
      if (r_state == STARTUP && w_next == STARTUP) begin
        r_su_cnt <= r_su_cnt + c_su_w'(1);
      end else begin
        r_su_cnt <= '0;
      end
    end
  end

  // Dropping pu beats every other transition.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      OFF: begin
        if (pu) w_next = STARTUP;
      end
      STARTUP: begin
        if (!pu)                        w_next = OFF;
        else if (r_su_cnt == c_su_last) w_next = RUN;
      end
      RUN: begin
        if (!pu) w_next = OFF;
      end
      default: w_next = OFF;
    endcase
  end

  assign w_load = (w_next == RUN) && (r_state != RUN);
  assign w_run  = (w_next == RUN) && (r_state == RUN);
  assign ready  = r_ready;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      osc_div_ch #(
        .SEL_W    (SEL_W),
        .BASE_LOG2(BASE_LOG2)
      ) u_ch (
        ._clk   (_clk),
        ._rst   (_rst),
        .load   (w_load),
        .run    (w_run),
        .sel    (sel[i*SEL_W +: SEL_W]),
        .en     (en[i]),
        .clk_out(clk_out[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_osc_multi_model.sv
// +--------------------------------------------------------------------------+
// | tb_osc_multi_model : scoreboard bench for osc_multi_model                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_osc_multi_model;

  localparam int N_CH        = 2;
  localparam int SEL_W       = 2;
  localparam int BASE_LOG2   = 2;
  localparam int STARTUP_CYC = 8;

  typedef struct {
    int   cyc;
    int   ch;
    logic lvl;
  } ev_t;

  logic                  _clk;
  logic                  _rst;
  logic                  pu;
  logic [N_CH-1:0]       en;
  logic [N_CH*SEL_W-1:0] sel;
  logic [N_CH-1:0]       clk_out;
  logic                  ready;

  int          cyc;
  int          n_chk;
  int          n_pass;
  bit          mon_en;
  logic [N_CH-1:0] prev;
  ev_t         exp_q[$];
  ev_t         mon_e;

  osc_multi_model #(
    .N_CH       (N_CH),
    .SEL_W      (SEL_W),
    .BASE_LOG2  (BASE_LOG2),
    .STARTUP_CYC(STARTUP_CYC)
  ) dut (
    ._clk   (_clk),
    ._rst   (_rst),
    .pu     (pu),
    .en     (en),
    .sel    (sel),
    .clk_out(clk_out),
    .ready  (ready)
  );

  initial begin
    _clk = 1'b0;
    forever #5 _clk = ~_clk;
  end

  initial cyc = 0;
  always @(posedge _clk) cyc <= cyc + 1;

  // Every output transition must match the next expected event, in cycle then channel order.
  always @(negedge _clk) begin
    for (int ch = 0; ch < N_CH; ch++) begin
      if (mon_en && clk_out[ch] !== prev[ch]) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_extra: ch%0d went to %b at edge %0d, required no transition", ch, clk_out[ch], cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc !== cyc || mon_e.ch !== ch || mon_e.lvl !== clk_out[ch])
            $display("FAIL sb_edge: got ch%0d->%b at edge %0d, required ch%0d->%b at edge %0d",
                     ch, clk_out[ch], cyc, mon_e.ch, mon_e.lvl, mon_e.cyc);
          else
            n_pass++;
        end
      end
    end
    prev = clk_out;
  end

  task automatic push(input int c, input int ch, input logic l);
    ev_t ev;
    int  i;
    ev.cyc = c;
    ev.ch  = ch;
    ev.lvl = l;
    i = 0;
    while (i < exp_q.size() && (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].ch < ch))) i++;
    exp_q.insert(i, ev);
  endtask

  // Constant half-period h from RUN-entry edge r: edge m*h toggles, odd m rises.
  task automatic push_periodic(input int r, input int h, input int ch, input int t_last);
    for (int m = 1; r + m * h <= t_last; m++) push(r + m * h, ch, (m % 2) == 1);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge _clk);
      #1;
    end
  endtask

  task automatic power_up(input logic [N_CH-1:0] en_v, input logic [N_CH*SEL_W-1:0] sel_v, output int r);
    int k;
    @(posedge _clk);
    #1;
    en  = en_v;
    sel = sel_v;
    pu  = 1'b1;
    k   = cyc + 1;
    wait_edge(k + STARTUP_CYC - 1);
    n_chk++;
    if (ready !== 1'b0) $display("FAIL ready_early: ready=%b at edge %0d, required 0", ready, cyc);
    else n_pass++;
    wait_edge(k + STARTUP_CYC);
    n_chk++;
    if (ready !== 1'b1 || clk_out !== '0)
      $display("FAIL ready_rise: ready=%b clk_out=%b at edge %0d, required 1/00", ready, clk_out, cyc);
    else n_pass++;
    r = k + STARTUP_CYC;
  endtask

  task automatic power_down(input int s);
    wait_edge(s - 1);
    pu = 1'b0;
    wait_edge(s);
    n_chk++;
    if (ready !== 1'b0 || clk_out !== '0)
      $display("FAIL pu_off: ready=%b clk_out=%b at edge %0d, required 0/00", ready, clk_out, cyc);
    else n_pass++;
    @(negedge _clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL sb_missing: %0d expected transitions never seen, required 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    _rst = 1'b0;
    pu   = 1'b0;
    en   = '0;
    sel  = '0;
    #2 _rst = 1'b1;
    #1;
    n_chk++;
    if (ready !== 1'b0 || clk_out !== '0)
      $display("FAIL reset_async: ready=%b clk_out=%b, required 0/00", ready, clk_out);
    else n_pass++;
    wait_edge(3);
    _rst = 1'b0;
    prev = clk_out;
    mon_en = 1'b1;
    wait_edge(12);
    n_chk++;
    if (ready !== 1'b0 || clk_out !== '0)
      $display("FAIL reset_idle: ready=%b clk_out=%b, required 0/00", ready, clk_out);
    else n_pass++;
  endtask

  task automatic test_basic();
    int r;
    power_up(2'b11, 4'b0000, r);
    push_periodic(r, 4, 0, r + 25);
    push_periodic(r, 4, 1, r + 25);
    power_down(r + 26);
  endtask

  task automatic test_sel_mix();
    int r;
    power_up(2'b11, {2'd3, 2'd0}, r);
    push_periodic(r, 4, 0, r + 65);
    push_periodic(r, 32, 1, r + 65);
    power_down(r + 66);
  endtask

  task automatic test_en_gate();
    int r;
    power_up(2'b11, 4'b0000, r);
    push(r + 4, 0, 1'b1);
    push(r + 8, 0, 1'b0);
    push(r + 20, 0, 1'b1);
    push(r + 24, 0, 1'b0);
    push_periodic(r, 4, 1, r + 25);
    wait_edge(r + 5);
    en = 2'b10;
    wait_edge(r + 13);
    en = 2'b11;
    power_down(r + 26);
  endtask

  task automatic test_sel_change();
    int r;
    power_up(2'b11, 4'b0000, r);
    push(r + 4, 0, 1'b1);
    push(r + 8, 0, 1'b0);
    push(r + 16, 0, 1'b1);
    push(r + 24, 0, 1'b0);
    push(r + 32, 0, 1'b1);
    push(r + 34, 0, 1'b0);
    push_periodic(r, 4, 1, r + 33);
    wait_edge(r + 5);
    sel = 4'b0001;
    power_down(r + 34);
  endtask

  task automatic test_pu_restart();
    int r;
    int k2;
    power_up(2'b11, 4'b0000, r);
    push(r + 4, 0, 1'b1);
    push(r + 4, 1, 1'b1);
    push(r + 6, 0, 1'b0);
    push(r + 6, 1, 1'b0);
    wait_edge(r + 5);
    pu = 1'b0;
    wait_edge(r + 6);
    n_chk++;
    if (ready !== 1'b0 || clk_out !== '0)
      $display("FAIL pu_drop_high: ready=%b clk_out=%b, required 0/00", ready, clk_out);
    else n_pass++;
    pu = 1'b1;
    k2 = r + 7;
    wait_edge(k2 + STARTUP_CYC - 1);
    n_chk++;
    if (ready !== 1'b0) $display("FAIL restart_early: ready=%b at edge %0d, required 0", ready, cyc);
    else n_pass++;
    wait_edge(k2 + STARTUP_CYC);
    n_chk++;
    if (ready !== 1'b1) $display("FAIL restart_ready: ready=%b at edge %0d, required 1", ready, cyc);
    else n_pass++;
    push_periodic(k2 + STARTUP_CYC, 4, 0, k2 + STARTUP_CYC + 9);
    push_periodic(k2 + STARTUP_CYC, 4, 1, k2 + STARTUP_CYC + 9);
    power_down(k2 + STARTUP_CYC + 10);
  endtask

  task automatic test_async_reset();
    int r;
    power_up(2'b11, 4'b0000, r);
    push(r + 4, 0, 1'b1);
    push(r + 4, 1, 1'b1);
    push(r + 5, 0, 1'b0);
    push(r + 5, 1, 1'b0);
    wait_edge(r + 5);
    #2;
    _rst = 1'b1;
    pu   = 1'b0;
    #1;
    n_chk++;
    if (ready !== 1'b0 || clk_out !== '0)
      $display("FAIL rst_async_run: ready=%b clk_out=%b, required 0/00", ready, clk_out);
    else n_pass++;
    wait_edge(r + 7);
    _rst = 1'b0;
    wait_edge(r + 12);
    n_chk++;
    if (ready !== 1'b0 || clk_out !== '0)
      $display("FAIL rst_wait_pu: ready=%b clk_out=%b, required 0/00", ready, clk_out);
    else n_pass++;
    power_up(2'b11, 4'b0000, r);
    push_periodic(r, 4, 0, r + 9);
    push_periodic(r, 4, 1, r + 9);
    power_down(r + 10);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_sel_mix();
    test_en_gate();
    test_sel_change();
    test_pu_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
